// File: rtl/fp32_norm_sched_pkg.sv
// Shared FP32 formats and normalizer scheduling constants.
package fp32_norm_sched_pkg;

  localparam int FX       = 25;
  localparam int NORM_LAT = 2;
  localparam int ID_W     = 3;

  // Expanded operand: mant[FX-1] is the carry-out bit, mant[FX-2] the hidden bit.
  typedef struct packed {
    logic          sign;
    logic [7:0]    exp;
    logic [FX-1:0] mant;
  } fp32x_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32n_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    fp32n_t          res;
    logic            under;
    logic            inexact;
  } rsp_ent_t;

endpackage

// File: rtl/fp32_norm_rsp_fifo.sv
// Response queue: synchronous FIFO of rsp_ent_t, head visible combinationally.
// Pushes when full and pops when empty are dropped; the scheduler's credits prevent both.
module fp32_norm_rsp_fifo
  import fp32_norm_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  rsp_ent_t                     i_dat,
  input  logic                         i_pop,
  output rsp_ent_t                     o_dat,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  rsp_ent_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dat     = r_mem[r_rd];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= ptr_inc(r_wr);
      if (w_pop_ok)  r_rd <= ptr_inc(r_rd);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_dat;
  end

endmodule

// File: rtl/fp32_norm_sched.sv
// Round-robin scheduler for the shared two-stage normalizer; credit-limited issue,
// tag pipe tracks requester IDs, results return in issue order via the response queue.
module fp32_norm_sched
  import fp32_norm_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  fp32x_t [NREQ-1:0]     req_x,
  input  logic [NREQ-1:0]       req_under,
  output fp32x_t                nrm_i,
  output logic                  nrm_under_i,
  input  fp32n_t                nrm_o,
  input  logic                  nrm_under_o,
  input  logic                  nrm_inexact_o,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output fp32n_t                rsp_o,
  output logic                  rsp_under,
  output logic                  rsp_inexact,
  output logic                  busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int OCW = $clog2(DEPTH+1);

  logic [IDW-1:0]                r_rr;
  logic [OCW-1:0]                r_occ;
  logic [NORM_LAT-1:0]           r_tag_v;
  logic [NORM_LAT-1:0][IDW-1:0]  r_tag_id;

  logic                          w_can;
  logic                          w_grant;
  logic [IDW-1:0]                w_gid;
  logic                          w_push;
  logic                          w_pop;
  rsp_ent_t                      w_push_dat;
  rsp_ent_t                      w_head;
  logic                          w_q_full;
  logic                          w_q_empty;
  logic [OCW-1:0]                w_q_count;

  // Reset gates issue so outputs read zero as soon as rst_n falls.
  assign w_can = rst_n && ce && (r_occ < OCW'(DEPTH));

  always_comb begin
    w_grant = 1'b0;
    w_gid   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_can && !w_grant && req_valid[(int'(r_rr) + i) % NREQ]) begin
        w_grant = 1'b1;
        w_gid   = IDW'((int'(r_rr) + i) % NREQ);
      end
    end
  end

  assign req_ready   = w_grant ? (NREQ'(1) << w_gid) : '0;
  assign nrm_i       = w_grant ? req_x[w_gid] : '0;
  assign nrm_under_i = w_grant && req_under[w_gid];

  assign w_push     = ce && r_tag_v[NORM_LAT-1];
  assign w_push_dat = '{id: ID_W'(r_tag_id[NORM_LAT-1]), res: nrm_o,
                        under: nrm_under_o, inexact: nrm_inexact_o};

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      rsp_valid[k] = !w_q_empty && (w_head.id == ID_W'(k));
    end
  end

  assign w_pop       = |(rsp_valid & rsp_ready);
  assign rsp_o       = w_head.res;
  assign rsp_under   = w_head.under;
  assign rsp_inexact = w_head.inexact;
  assign busy        = (r_occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr     <= '0;
      r_occ    <= '0;
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      if (w_grant) r_rr <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
      if (w_grant && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (w_pop && !w_grant) r_occ <= r_occ - 1'b1;
      if (ce) begin
        r_tag_v[0]  <= w_grant;
        r_tag_id[0] <= w_gid;
        for (int s = 1; s < NORM_LAT; s++) begin
          r_tag_v[s]  <= r_tag_v[s-1];
          r_tag_id[s] <= r_tag_id[s-1];
        end
      end
    end
  end

  fp32_norm_rsp_fifo #(.DEPTH(DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  // Credits cover every queued entry, so the queue can never overflow.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_q_full));
  a_occ_covers:  assert property (@(posedge clk) disable iff (!rst_n) w_q_count <= r_occ);

endmodule

// File: tb/tb_fp32_norm_sched.sv
// Directed bench for fp32_norm_sched with a behavioural two-stage normalizer.
module tb_fp32_norm_sched;
  import fp32_norm_sched_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ce = 1'b0;
  logic [3:0]     req_valid = '0;
  logic [3:0]     req_ready;
  fp32x_t [3:0]   req_x;
  logic [3:0]     req_under = '0;
  fp32x_t         nrm_i;
  logic           nrm_under_i;
  fp32n_t         nrm_o;
  logic           nrm_under_o;
  logic           nrm_inexact_o;
  logic [3:0]     rsp_valid;
  logic [3:0]     rsp_ready = '0;
  fp32n_t         rsp_o;
  logic           rsp_under;
  logic           rsp_inexact;
  logic           busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp32_norm_sched dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_under(req_under),
    .nrm_i(nrm_i), .nrm_under_i(nrm_under_i),
    .nrm_o(nrm_o), .nrm_under_o(nrm_under_o), .nrm_inexact_o(nrm_inexact_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_o(rsp_o),
    .rsp_under(rsp_under), .rsp_inexact(rsp_inexact), .busy(busy)
  );

  typedef struct packed {
    fp32n_t r;
    logic   u;
    logic   inx;
  } nres_t;

  function automatic nres_t norm_f(input fp32x_t x, input logic u);
    nres_t n;
    n.r.sign = x.sign;
    n.u      = u;
    if (x.mant[FX-1]) begin
      n.r.exp  = x.exp + 8'd1;
      n.r.frac = x.mant[23:1];
      n.inx    = x.mant[0];
    end else begin
      n.r.exp  = x.exp;
      n.r.frac = x.mant[22:0];
      n.inx    = 1'b0;
    end
    return n;
  endfunction

  nres_t n1, n2;
  always_ff @(posedge clk) begin
    if (ce) begin
      n1 <= norm_f(nrm_i, nrm_under_i);
      n2 <= n1;
    end
  end
  assign nrm_o         = n2.r;
  assign nrm_under_o   = n2.u;
  assign nrm_inexact_o = n2.inx;

  typedef struct {
    logic [3:0] v;
    logic [3:0] rrdy;
    logic       c;
    logic [3:0] x_rr;
    logic [3:0] x_rv;
    logic       x_busy;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic [3:0] v, input logic [3:0] rrdy, input logic c,
                              input logic [3:0] x_rr, input logic [3:0] x_rv, input logic x_busy);
    row_t r;
    r.v = v; r.rrdy = rrdy; r.c = c; r.x_rr = x_rr; r.x_rv = x_rv; r.x_busy = x_busy;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Operand k: exponent 0x7E+k with carry bit set -> result exponent 0x7F+k, inexact = k[0].
  task automatic check_outputs(input int idx, input row_t r);
    int k;
    chk("req_ready", idx, 32'(req_ready), 32'(r.x_rr));
    chk("rsp_valid", idx, 32'(rsp_valid), 32'(r.x_rv));
    chk("busy", idx, 32'(busy), 32'(r.x_busy));
    if (r.x_rv != 4'b0000) begin
      k = 0;
      for (int b = 0; b < 4; b++) if (r.x_rv[b]) k = b;
      chk("rsp_exp", idx, 32'(rsp_o.exp), 32'(8'h7F + 8'(k)));
      chk("rsp_inexact", idx, 32'(rsp_inexact), 32'(k % 2));
    end
  endtask

  task automatic run_row(input int idx, input row_t r);
    req_valid = r.v;
    rsp_ready = r.rrdy;
    ce        = r.c;
    @(negedge clk);
    check_outputs(idx, r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      req_x[k].sign = 1'b0;
      req_x[k].exp  = 8'h7E + 8'(k);
      req_x[k].mant = {1'b1, 24'(k)};
    end

    // Single op from requester 2 (after reset rr=0, ends with rr=3)
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 0));
    rows.push_back(mk(4'h4, 4'hF, 1, 4'b0100, 4'b0000, 0));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0100, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 0));
    // Streaming, all requesters valid, consumers ready: grants 3,0,1,2,3,0,1
    rows.push_back(mk(4'hF, 4'hF, 1, 4'b1000, 4'b0000, 0));
    rows.push_back(mk(4'hF, 4'hF, 1, 4'b0001, 4'b0000, 1));
    rows.push_back(mk(4'hF, 4'hF, 1, 4'b0010, 4'b0000, 1));
    rows.push_back(mk(4'hF, 4'hF, 1, 4'b0100, 4'b1000, 1));
    rows.push_back(mk(4'hF, 4'hF, 1, 4'b1000, 4'b0001, 1));
    rows.push_back(mk(4'hF, 4'hF, 1, 4'b0001, 4'b0010, 1));
    rows.push_back(mk(4'hF, 4'hF, 1, 4'b0010, 4'b0100, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b1000, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0001, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0010, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 0));
    // Credits exhausted with no consumer, then one pop frees one grant (rr=2)
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b0100, 4'b0000, 0));
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b1000, 4'b0000, 1));
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b0001, 4'b0000, 1));
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b0010, 4'b0100, 1));
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b0000, 4'b0100, 1));
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b0000, 4'b0100, 1));
    rows.push_back(mk(4'hF, 4'h4, 1, 4'b0000, 4'b0100, 1));
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b0100, 4'b1000, 1));
    rows.push_back(mk(4'hF, 4'h0, 1, 4'b0000, 4'b1000, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b1000, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0001, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0010, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0100, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 0));
    // Head-of-line: req 1 then req 3 issued, requester 1 stalls (rr=3)
    rows.push_back(mk(4'h2, 4'h8, 1, 4'b0010, 4'b0000, 0));
    rows.push_back(mk(4'h8, 4'h8, 1, 4'b1000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'h8, 1, 4'b0000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'h8, 1, 4'b0000, 4'b0010, 1));
    rows.push_back(mk(4'h0, 4'h8, 1, 4'b0000, 4'b0010, 1));
    rows.push_back(mk(4'h0, 4'h8, 1, 4'b0000, 4'b0010, 1));
    rows.push_back(mk(4'h0, 4'h2, 1, 4'b0000, 4'b0010, 1));
    rows.push_back(mk(4'h0, 4'h8, 1, 4'b0000, 4'b1000, 1));
    rows.push_back(mk(4'h0, 4'h8, 1, 4'b0000, 4'b0000, 0));
    // Clock-enable toggling on a single op from requester 0; pop lands on a ce=0 cycle
    rows.push_back(mk(4'h1, 4'hF, 1, 4'b0001, 4'b0000, 0));
    rows.push_back(mk(4'h1, 4'hF, 0, 4'b0000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'hF, 0, 4'b0000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 1));
    rows.push_back(mk(4'h0, 4'hF, 0, 4'b0000, 4'b0001, 1));
    rows.push_back(mk(4'h0, 4'hF, 1, 4'b0000, 4'b0000, 0));

    // Reset state with requests already asserted
    req_valid = 4'hF;
    ce        = 1'b1;
    #12;
    chk("reset_req_ready", 0, 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 0, 32'(rsp_valid), 32'h0);
    chk("reset_busy", 0, 32'(busy), 32'h0);
    chk("reset_nrm_i", 0, 32'(nrm_i.exp), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) run_row(i + 1, rows[i]);

    // Asynchronous reset with three ops in flight (rr=1: grants 1,2,3)
    run_row(100, mk(4'hF, 4'h0, 1, 4'b0010, 4'b0000, 0));
    run_row(101, mk(4'hF, 4'h0, 1, 4'b0100, 4'b0000, 1));
    run_row(102, mk(4'hF, 4'h0, 1, 4'b1000, 4'b0000, 1));
    @(negedge clk);
    chk("pre_reset_rsp_valid", 103, 32'(rsp_valid), 32'h2);
    chk("pre_reset_req_ready", 103, 32'(req_ready), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req_ready", 104, 32'(req_ready), 32'h0);
    chk("async_rsp_valid", 104, 32'(rsp_valid), 32'h0);
    chk("async_busy", 104, 32'(busy), 32'h0);
    chk("async_nrm_i", 104, 32'(nrm_i.exp), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'h0;
    rsp_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_rsp_valid", 110 + i, 32'(rsp_valid), 32'h0);
      chk("post_reset_busy", 110 + i, 32'(busy), 32'h0);
      @(posedge clk);
      #1;
    end
    req_valid = 4'hF;
    @(negedge clk);
    chk("post_reset_rr_start", 120, 32'(req_ready), 32'h1);
    chk("post_reset_nrm_i_exp", 120, 32'(nrm_i.exp), 32'(8'h7E));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fp32_norm_sched.md
# fp32_norm_sched

Shared-resource scheduler for the 32-bit normalization unit: arbitrates up to NREQ producers (adder, multiplier, divider, int→float converter) onto one two-register-stage normalizer, tracks each in-flight operation by requester ID, and returns results in issue order through a small response queue with valid/ready backpressure. It sits between the FP operator front-ends and the rounding stage, driving the normalizer's input and capturing its output. Issue is credit-limited so no normalizer result is ever dropped.

## Interface
- NREQ, 4: number of requesters (2..8).
- NORM_LAT, 2: normalizer latency in ce-qualified clock edges (fp32Pkg::NORM_LAT).
- DEPTH, 4: response queue depth; must be ≥ NORM_LAT+2 for full throughput.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; the same signal drives the normalizer's ce.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[k]&&req_ready[k].
- req_x  in  NREQ×FP32X  expanded-format operands.
- req_under  in  NREQ  per-requester underflow flag.
- nrm_i  out  FP32X  normalizer input (granted operand, zero when idle).
- nrm_under_i  out  1  normalizer underflow input.
- nrm_o  in  FP32N  normalizer result.
- nrm_under_o, nrm_inexact_o  in  1 each  normalizer status.
- rsp_valid  out  NREQ  one-hot: head result belongs to requester k.
- rsp_ready  in  NREQ  per-requester accept.
- rsp_o  out  FP32N  head result (shared bus).
- rsp_under, rsp_inexact  out  1 each  head status.
- busy  out  1  occ≠0.

## Operation
- Arbitration: round-robin over req_valid starting at pointer rr; grant only when ce=1 and occ<DEPTH. req_ready is combinational from req_valid, rr, occ, ce. On grant to k, rr←(k+1) mod NREQ; no grant leaves rr unchanged.
- Issue: nrm_i/nrm_under_i = granted req_x/req_under; all-zero when no grant.
- Tag pipe: NORM_LAT stages of {v, id[$clog2(NREQ)-1:0]}, shifts only when ce=1; stage0 ← {grant, granted id}.
- Capture: on a ce=1 edge with last tag stage v=1, push {id, nrm_o, nrm_under_o, nrm_inexact_o} into the queue. Bubbles (v=0) never push.
- Output: queue head drives rsp_o/rsp_under/rsp_inexact; rsp_valid[head.id]=1 when non-empty, else all 0. Pop on rsp_valid[k]&&rsp_ready[k]; pop is independent of ce. In-order delivery; a stalled requester blocks later results (documented head-of-line behaviour).
- Credit: occ (0..DEPTH) +1 on grant, −1 on pop; both in one cycle → unchanged. occ counts tag-pipe entries plus queue entries, so a push never finds the queue full; a push into a full queue is an assertion failure.
- Reset (any time, including mid-operation): tag pipe v=0, queue empty, occ=0, rr=0; rsp_valid=0, req_ready=0, busy=0, nrm_i=0. Normalizer contents are ignored after reset because all tags are invalid.

## Timing
- Grant at edge t (ce=1 throughout) → push at edge t+NORM_LAT+1 → rsp_valid high in the cycle after; 3-cycle accept-to-response at default.
- ce=0 cycles freeze tag pipe and arbitration, adding one cycle of latency each; pops still proceed.
- Throughput: one issue per ce cycle sustained when DEPTH≥NORM_LAT+2 and consumers always ready.
- Grant when occ==DEPTH is never issued, even with a same-cycle pop (no bypass).

## Structure
- fp32Pkg gains: NORM_LAT localparam and the typedef for a response entry {id, FP32N, under, inexact}. FP32X/FP32N are already in the package.
- One sub-module: fp32_norm_rsp_fifo (synchronous FIFO, async active-low reset, push/pop/full/empty/count). Arbiter, tag pipe and credit counter stay inline.

## Test plan
- Single op: req 2, exp 8'h80, bit FX−1 set, ce=1 → req_ready=4'b0100 same cycle; rsp_valid=4'b0100 three cycles later, rsp_o.exp=8'h81.
- All four valid continuously, rsp_ready=4'hF → grants 0,1,2,3,0… one per cycle; responses in same order, no gaps after fill.
- rsp_ready=0 for all, all valid → exactly 4 grants, then req_ready=0 with occ=4; raise rsp_ready[0] → one pop, one new grant the next cycle.
- ce toggled 1,0,1,0 during a single op → response after 3 ce=1 edges plus 1 cycle; tag pipe holds during ce=0.
- Head-of-line: results for reqs 1 then 3 queued, rsp_ready[1]=0 → rsp_valid stays 4'b0010, req 3 result not visible until req 1 pops.
- rst_n low with 3 ops in flight → all outputs zero immediately (async); after release, no stale response ever appears, rr restarts at requester 0.
